// File: rtl/dlx_gpr_pkg.sv
// Shared GPR-file constants for the DLX datapath: widths and fixed register
// addresses used by the write-back queue and its neighbours.
package dlx_gpr_pkg;
    localparam int GPR_AW = 5;
    localparam int GPR_DW = 32;
    localparam logic [4:0] R0_ADR      = 5'd0;
    localparam logic [4:0] SHARP_E_ADR = 5'd10;
endpackage

// File: rtl/gpr_wb_fifo.sv
// In-order storage for pending GPR writes: circular array with head/tail
// pointers, an occupancy count and a per-entry valid bit for hazard compares.
module gpr_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [AW-1:0]            i_adr,
    input  logic [DW-1:0]            i_data,
    input  logic                     i_pop,
    output logic [AW-1:0]            o_head_adr,
    output logic [DW-1:0]            o_head_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [DEPTH-1:0]         o_valid,
    output logic [AW-1:0]            o_adr [DEPTH]
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    r_adr  [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    // Guards make the array safe even if the caller ignores full/empty.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_push) begin
                r_adr[r_tail]   <= i_adr;
                r_data[r_tail]  <= i_data;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_adr  = r_adr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_count     = r_count;
    assign o_valid     = r_valid;
    assign o_adr       = r_adr;
endmodule

// File: rtl/gpr_wb_queue.sv
// GPR write-back front end: buffers write requests in order and issues them
// only in granted write slots, reporting RAW hazards for the decode sources.
module gpr_wb_queue
    import dlx_gpr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = GPR_DW,
    parameter int AW    = GPR_AW
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AW-1:0]          req_adr,
    input  logic [DW-1:0]          req_data,
    input  logic                   wb_slot,
    output logic                   GPR_WE,
    output logic [AW-1:0]          C_ADR,
    output logic [DW-1:0]          C,
    input  logic [AW-1:0]          rd_adr_a,
    input  logic [AW-1:0]          rd_adr_b,
    output logic                   hazard_a,
    output logic                   hazard_b,
    output logic                   pending,
    output logic [$clog2(DEPTH):0] count
);
    localparam logic [AW-1:0] W_R0 = AW'(R0_ADR);

    logic [AW-1:0]    w_head_adr;
    logic [DW-1:0]    w_head_data;
    logic             w_full;
    logic             w_empty;
    logic [DEPTH-1:0] w_valid;
    logic [AW-1:0]    w_adr [DEPTH];
    logic             w_store;
    logic             w_hit_a;
    logic             w_hit_b;

    // Handshake: a request transfers at the edge where req_valid && req_ready;
    // req_ready depends only on occupancy, never on req_valid or wb_slot.
    assign req_ready = !w_full;
    assign w_store   = req_valid && req_ready && (req_adr != W_R0);
    assign pending   = !w_empty;
    assign GPR_WE    = wb_slot && pending;
    assign C_ADR     = pending ? w_head_adr  : '0;
    assign C         = pending ? w_head_data : '0;

    gpr_wb_fifo #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_store),
        .i_adr       (req_adr),
        .i_data      (req_data),
        .i_pop       (GPR_WE),
        .o_head_adr  (w_head_adr),
        .o_head_data (w_head_data),
        .o_count     (count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_valid     (w_valid),
        .o_adr       (w_adr)
    );

    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_adr[i] == rd_adr_a)) w_hit_a = 1'b1;
            if (w_valid[i] && (w_adr[i] == rd_adr_b)) w_hit_b = 1'b1;
        end
    end

    // The entry popping this cycle still counts: reads are blocked anyway.
    assign hazard_a = (rd_adr_a != W_R0) && (w_hit_a || (w_store && (req_adr == rd_adr_a)));
    assign hazard_b = (rd_adr_b != W_R0) && (w_hit_b || (w_store && (req_adr == rd_adr_b)));
endmodule

// File: tb/tb_gpr_wb_queue.sv
// Directed bench for gpr_wb_queue: a queue-based model checked every cycle
// plus literal expectations for each scenario.
module tb_gpr_wb_queue;
  localparam int DEPTH = 4;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset_n;
  logic req_valid;
  logic req_ready;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_data;
  logic wb_slot;
  logic gpr_we;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_data;
  logic [AW-1:0] rd_adr_a;
  logic [AW-1:0] rd_adr_b;
  logic hazard_a;
  logic hazard_b;
  logic pending;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_fail = 0;
  logic model_on = 1'b0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  gpr_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_adr(req_adr), .req_data(req_data),
    .wb_slot(wb_slot), .GPR_WE(gpr_we), .C_ADR(c_adr), .C(c_data),
    .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .pending(pending), .count(count)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic slot);
    req_valid = v;
    req_adr = adr;
    req_data = dat;
    wb_slot = slot;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Model: outputs follow from the list of stored writes and this cycle's inputs.
  always @(negedge clk) begin
    int sz;
    logic ea, eb, acc, pop;
    if (model_on) begin
      sz = exp_q.size();
      acc = req_valid && (sz != DEPTH) && (req_adr != 0);
      pop = wb_slot && (sz != 0);
      ea = 1'b0;
      eb = 1'b0;
      foreach (exp_q[i]) begin
        if (exp_q[i][AW+DW-1:DW] == rd_adr_a) ea = 1'b1;
        if (exp_q[i][AW+DW-1:DW] == rd_adr_b) eb = 1'b1;
      end
      if (acc && req_adr == rd_adr_a) ea = 1'b1;
      if (acc && req_adr == rd_adr_b) eb = 1'b1;
      if (rd_adr_a == 0) ea = 1'b0;
      if (rd_adr_b == 0) eb = 1'b0;
      check("m_ready", 64'(req_ready), 64'(sz != DEPTH));
      check("m_pending", 64'(pending), 64'(sz != 0));
      check("m_count", 64'(count), 64'(sz));
      check("m_we", 64'(gpr_we), 64'(pop));
      check("m_c_adr", 64'(c_adr), (sz != 0) ? 64'(exp_q[0][AW+DW-1:DW]) : 64'd0);
      check("m_c", 64'(c_data), (sz != 0) ? 64'(exp_q[0][DW-1:0]) : 64'd0);
      check("m_haz_a", 64'(hazard_a), 64'(ea));
      check("m_haz_b", 64'(hazard_b), 64'(eb));
      if (!reset_n) begin
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({req_adr, req_data});
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    rd_adr_a = '0;
    rd_adr_b = '0;
    drive(0, 0, 0, 0);
    tick();
    model_on = 1'b1;
    tick();
    reset_n = 1'b1;

    // Reset state
    at_neg();
    check("rst_count", 64'(count), 64'd0);
    check("rst_we", 64'(gpr_we), 64'd0);
    check("rst_c_adr", 64'(c_adr), 64'd0);
    check("rst_c", 64'(c_data), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    tick();

    // 1: single write held off until a slot is granted
    rd_adr_a = 5'd3;
    drive(1, 5'd3, 32'hDEADBEEF, 0);
    at_neg();
    check("t1_haz_incoming", 64'(hazard_a), 64'd1);
    check("t1_no_bypass", 64'(pending), 64'd0);
    tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("t1_hold_we", 64'(gpr_we), 64'd0);
      check("t1_hold_pend", 64'(pending), 64'd1);
      check("t1_hold_haz", 64'(hazard_a), 64'd1);
      tick();
    end
    drive(0, 0, 0, 1);
    at_neg();
    check("t1_we", 64'(gpr_we), 64'd1);
    check("t1_c_adr", 64'(c_adr), 64'd3);
    check("t1_c", 64'(c_data), 64'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0);
    at_neg();
    check("t1_drained", 64'(pending), 64'd0);
    check("t1_haz_clear", 64'(hazard_a), 64'd0);
    tick();

    // 2: R0 writes are accepted and dropped
    rd_adr_a = 5'd0;
    drive(1, 5'd0, 32'h1234, 1);
    at_neg();
    check("t2_ready", 64'(req_ready), 64'd1);
    check("t2_haz", 64'(hazard_a), 64'd0);
    tick();
    drive(0, 0, 0, 1);
    at_neg();
    check("t2_count", 64'(count), 64'd0);
    check("t2_we", 64'(gpr_we), 64'd0);
    tick();

    // 3/4: fill, block the fifth, then drain with the fifth entering after the first pop
    for (int i = 1; i <= 4; i++) begin
      drive(1, AW'(i), DW'(i * 32'h11), 0);
      tick();
    end
    drive(1, 5'd5, 32'h55, 0);
    at_neg();
    check("t3_full_ready", 64'(req_ready), 64'd0);
    check("t3_full_count", 64'(count), 64'd4);
    tick();
    drive(1, 5'd5, 32'h55, 1);
    at_neg();
    check("t4_pop_we", 64'(gpr_we), 64'd1);
    check("t4_pop_adr", 64'(c_adr), 64'd1);
    check("t4_no_push", 64'(req_ready), 64'd0);
    tick();
    at_neg();
    check("t4_count3", 64'(count), 64'd3);
    check("t4_ready", 64'(req_ready), 64'd1);
    check("t3_adr2", 64'(c_adr), 64'd2);
    tick();
    drive(0, 0, 0, 1);
    for (int i = 3; i <= 5; i++) begin
      at_neg();
      check("t3_order", 64'(c_adr), 64'(i));
      check("t3_data", 64'(c_data), 64'(i * 32'h11));
      tick();
    end
    at_neg();
    check("t3_empty", 64'(pending), 64'd0);
    tick();

    // 5: same-register writes land in order, hazard held until the last pops
    rd_adr_b = 5'd7;
    drive(1, 5'd7, 32'hA, 0);
    tick();
    drive(1, 5'd7, 32'hB, 0);
    tick();
    drive(0, 0, 0, 1);
    at_neg();
    check("t5_first", 64'(c_data), 64'hA);
    check("t5_haz1", 64'(hazard_b), 64'd1);
    tick();
    at_neg();
    check("t5_second", 64'(c_data), 64'hB);
    check("t5_haz2", 64'(hazard_b), 64'd1);
    tick();
    drive(0, 0, 0, 0);
    at_neg();
    check("t5_haz_clear", 64'(hazard_b), 64'd0);
    tick();

    // 6: reset mid-drain discards everything
    rd_adr_a = 5'd10;
    for (int i = 9; i <= 11; i++) begin
      drive(1, AW'(i), DW'(i), 0);
      tick();
    end
    drive(0, 0, 0, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("t6_count", 64'(count), 64'd0);
      check("t6_we", 64'(gpr_we), 64'd0);
      check("t6_haz", 64'(hazard_a), 64'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
